// File: rtl/bus_arb4_16.sv
// Round-robin arbiter sharing one 16-bit bus port between four requesters.
// Holds each grant until ack_i, or until the timeout counter forces release.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; the next request is arbitrated from ptr onwards
// ST_BUSY | one requester granted; waiting for ack_i or the timeout
module bus_arb4_16 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_i,
  input  logic        ack_i,
  input  logic [15:0] dat0_i,
  input  logic [15:0] dat1_i,
  input  logic [15:0] dat2_i,
  input  logic [15:0] dat3_i,
  output logic [3:0]  gnt_o,
  output logic [1:0]  sel_o,
  output logic        cyc_o,
  output logic [15:0] dat_o,
  output logic        timeout_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // The timer counts down from TIMEOUT-1; reaching zero means TIMEOUT busy cycles.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] offs;
  logic [1:0] winner;

  // Rotate requests so bit 0 is the requester at ptr, then pick the lowest set bit.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr;
    req_rot = req_dbl[3:0];
    offs    = 2'd0;
    if (req_rot[0])      offs = 2'd0;
    else if (req_rot[1]) offs = 2'd1;
    else if (req_rot[2]) offs = 2'd2;
    else if (req_rot[3]) offs = 2'd3;
    winner = ptr + offs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
      gnt_o     <= 4'b0000;
      sel_o     <= 2'd0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            sel_o <= winner;
            gnt_o <= 4'b0001 << winner;
            cnt   <= TMO_LOAD;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (ack_i || (cnt == 8'd0)) begin
            gnt_o     <= 4'b0000;
            ptr       <= sel_o + 2'd1;
            state     <= ST_IDLE;
            timeout_o <= ~ack_i;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          gnt_o <= 4'b0000;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cyc_o = |gnt_o;

  always_comb begin
    case (sel_o)
      2'd0:    dat_o = dat0_i;
      2'd1:    dat_o = dat1_i;
      2'd2:    dat_o = dat2_i;
      default: dat_o = dat3_i;
    endcase
  end

endmodule
